// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller: tracks in-flight destinations, drives EX operand selects and load-use stalls.
// Latency: stall_id is combinational; ex_valid/fwd_a/fwd_b/stall_count update on the clock edge that advances ID into EX.
// Backpressure: ex_hold freezes all state and asserts stall_id; a load-use hazard stalls ID for one cycle and sends a bubble into EX.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_rd_we,
    input  logic        id_is_load,
    input  logic        flush,
    input  logic        ex_hold,
    output logic        stall_id,
    output logic        ex_valid,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [31:0] stall_count
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
    } dst_t;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_EXM  = 2'b01;
    localparam logic [1:0] FWD_MWB  = 2'b10;

    // WB-stage producers need no tracking: the register file writes through in the same cycle.
    dst_t ex_dst;
    dst_t mem_dst;
    logic ex_is_load;

    logic load_use;
    logic issue;
    logic [1:0] fwd_a_nxt;
    logic [1:0] fwd_b_nxt;

    function automatic logic hit(input dst_t s, input logic [4:0] rs, input logic use_rs);
        return s.valid & s.we & (s.rd != 5'd0) & (s.rd == rs) & use_rs;
    endfunction

    // The youngest producer wins, so the EX entry is checked before MEM.
    function automatic logic [1:0] fwd_sel(input dst_t ex_s, input dst_t mem_s,
                                           input logic [4:0] rs, input logic use_rs);
        if (hit(ex_s, rs, use_rs))
            return FWD_EXM;
        else if (hit(mem_s, rs, use_rs))
            return FWD_MWB;
        else
            return FWD_NONE;
    endfunction

    assign load_use  = id_valid & ex_is_load &
                       (hit(ex_dst, id_rs1, id_use_rs1) | hit(ex_dst, id_rs2, id_use_rs2));
    assign issue     = id_valid & ~load_use & ~flush;
    assign fwd_a_nxt = fwd_sel(ex_dst, mem_dst, id_rs1, id_use_rs1);
    assign fwd_b_nxt = fwd_sel(ex_dst, mem_dst, id_rs2, id_use_rs2);

    assign stall_id  = ex_hold | (load_use & ~flush);
    assign ex_valid  = ex_dst.valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_dst      <= '0;
            mem_dst     <= '0;
            ex_is_load  <= 1'b0;
            fwd_a       <= FWD_NONE;
            fwd_b       <= FWD_NONE;
            stall_count <= 32'd0;
        end else if (!ex_hold) begin
            mem_dst <= ex_dst;
            if (issue) begin
                ex_dst     <= '{valid: 1'b1, rd: id_rd, we: id_rd_we};
                ex_is_load <= id_is_load;
                fwd_a      <= fwd_a_nxt;
                fwd_b      <= fwd_b_nxt;
            end else begin
                ex_dst     <= '0;
                ex_is_load <= 1'b0;
                fwd_a      <= FWD_NONE;
                fwd_b      <= FWD_NONE;
            end
            if (load_use && !flush)
                stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table with hand-derived expectations, then random traffic vs a reference model.
// Latency: checks are taken mid-cycle; backpressure: ex_hold exercised in both phases.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_use_rs1, id_use_rs2, id_rd_we, id_is_load, flush, ex_hold;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        stall_id, ex_valid;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_count;

    int tests = 0;
    int fails = 0;

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
        .flush(flush), .ex_hold(ex_hold),
        .stall_id(stall_id), .ex_valid(ex_valid),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       we, ld, fl, hd;
        logic       e_st, e_exv;
        logic [1:0] e_fa, e_fb;
        int         e_cnt;
    } vec_t;

    // Reference model: list of instructions in flight, index 0 is one stage ahead of ID (EX), index 1 two ahead (MEM).
    typedef struct {
        bit       valid;
        bit [4:0] rd;
        bit       we;
        bit       ld;
    } ins_t;

    ins_t     flight [2];
    bit [1:0] m_fa, m_fb;
    int       m_cnt;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) flight[d] = '{default: 0};
        m_fa = 0; m_fb = 0; m_cnt = 0;
    endtask

    // Distance (1 or 2) to the nearest in-flight writer of rs, 0 if none.
    function automatic int producer_dist(bit [4:0] rs, bit use_rs);
        if (!use_rs || rs == 0) return 0;
        for (int d = 0; d < 2; d++)
            if (flight[d].valid && flight[d].we && flight[d].rd == rs) return d + 1;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic vec_t mk(logic v, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                                logic [4:0] rd, logic we, logic ld, logic fl, logic hd,
                                logic e_st, logic e_exv, logic [1:0] e_fa, logic [1:0] e_fb, int e_cnt);
        vec_t r;
        r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.rd = rd;
        r.we = we; r.ld = ld; r.fl = fl; r.hd = hd;
        r.e_st = e_st; r.e_exv = e_exv; r.e_fa = e_fa; r.e_fb = e_fb; r.e_cnt = e_cnt;
        return r;
    endfunction

    // Drive one cycle of ID inputs, compare mid-cycle, then advance the model on the edge.
    task automatic step(input vec_t r, input bit use_tbl, input int idx);
        bit lu, mst;
        int d1, d2;
        @(negedge clk);
        id_valid = r.v; id_rs1 = r.rs1; id_rs2 = r.rs2; id_use_rs1 = r.u1; id_use_rs2 = r.u2;
        id_rd = r.rd; id_rd_we = r.we; id_is_load = r.ld; flush = r.fl; ex_hold = r.hd;
        #1;
        d1  = producer_dist(r.rs1, r.u1);
        d2  = producer_dist(r.rs2, r.u2);
        lu  = r.v && flight[0].valid && flight[0].ld && (d1 == 1 || d2 == 1);
        mst = r.hd || (lu && !r.fl);
        chk("mdl_stall_id", stall_id, mst);
        chk("mdl_ex_valid", ex_valid, flight[0].valid);
        chk("mdl_fwd_a", fwd_a, m_fa);
        chk("mdl_fwd_b", fwd_b, m_fb);
        chk("mdl_stall_count", stall_count, m_cnt);
        if (use_tbl) begin
            chk($sformatf("row%0d_stall_id", idx), stall_id, r.e_st);
            chk($sformatf("row%0d_ex_valid", idx), ex_valid, r.e_exv);
            chk($sformatf("row%0d_fwd_a", idx), fwd_a, r.e_fa);
            chk($sformatf("row%0d_fwd_b", idx), fwd_b, r.e_fb);
            chk($sformatf("row%0d_stall_count", idx), stall_count, r.e_cnt);
        end
        @(posedge clk);
        if (!r.hd) begin
            flight[1] = flight[0];
            if (r.v && !lu && !r.fl) begin
                flight[0] = '{valid: 1, rd: r.rd, we: r.we, ld: r.ld};
                m_fa = (d1 == 1) ? 2'b01 : (d1 == 2) ? 2'b10 : 2'b00;
                m_fb = (d2 == 1) ? 2'b01 : (d2 == 2) ? 2'b10 : 2'b00;
            end else begin
                flight[0] = '{default: 0};
                m_fa = 0; m_fb = 0;
            end
            if (lu && !r.fl) m_cnt = m_cnt + 1;
        end
    endtask

    vec_t tbl [$];
    vec_t rv;

    initial begin
        rst_n = 1'b0;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd = 0; id_rd_we = 0; id_is_load = 0; flush = 0; ex_hold = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        //            v  rs1 rs2 u1 u2 rd  we ld fl hd | st exv fa fb cnt
        tbl.push_back(mk(1,  1,  2, 1, 1,  5, 1, 0, 0, 0,  0, 0, 0, 0, 0)); // add x5
        tbl.push_back(mk(1,  5,  1, 1, 1,  6, 1, 0, 0, 0,  0, 1, 0, 0, 0)); // add x6,x5,x1
        tbl.push_back(mk(1,  1,  2, 1, 1,  9, 1, 0, 0, 0,  0, 1, 1, 0, 0)); // independent
        tbl.push_back(mk(1,  1,  6, 1, 1,  7, 1, 0, 0, 0,  0, 1, 0, 0, 0)); // x6 at distance 2
        tbl.push_back(mk(1,  2,  6, 1, 1, 10, 1, 0, 0, 0,  0, 1, 0, 2, 0)); // x6 at distance 3
        tbl.push_back(mk(1,  1,  0, 1, 0,  7, 1, 1, 0, 0,  0, 1, 0, 0, 0)); // lw x7
        tbl.push_back(mk(1,  7,  7, 1, 1,  8, 1, 0, 0, 0,  1, 1, 0, 0, 0)); // add x8,x7,x7 stalls
        tbl.push_back(mk(1,  7,  7, 1, 1,  8, 1, 0, 0, 0,  0, 0, 0, 0, 1)); // reissue, EX bubble
        tbl.push_back(mk(1,  1,  2, 1, 1,  0, 1, 0, 0, 0,  0, 1, 2, 2, 1)); // writer of x0
        tbl.push_back(mk(1,  0,  0, 1, 1, 11, 1, 0, 0, 0,  0, 1, 0, 0, 1)); // reader of x0
        tbl.push_back(mk(1,  3, 11, 1, 0, 12, 1, 0, 0, 0,  0, 1, 0, 0, 1)); // rs2 match but unused
        tbl.push_back(mk(1,  1,  0, 1, 0,  7, 1, 1, 0, 0,  0, 1, 0, 0, 1)); // lw x7
        tbl.push_back(mk(1,  7,  1, 1, 1,  8, 1, 0, 1, 0,  0, 1, 0, 0, 1)); // dependent + flush
        tbl.push_back(mk(0,  0,  0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 1)); // idle
        tbl.push_back(mk(1,  1,  2, 1, 1,  5, 1, 0, 0, 0,  0, 0, 0, 0, 1)); // add x5
        tbl.push_back(mk(1,  5,  5, 1, 1,  6, 1, 0, 0, 0,  0, 1, 0, 0, 1)); // add x6,x5,x5
        tbl.push_back(mk(1,  6,  1, 1, 1, 13, 1, 0, 0, 1,  1, 1, 1, 1, 1)); // hold 1
        tbl.push_back(mk(1,  6,  1, 1, 1, 13, 1, 0, 0, 1,  1, 1, 1, 1, 1)); // hold 2
        tbl.push_back(mk(1,  6,  1, 1, 1, 13, 1, 0, 1, 1,  1, 1, 1, 1, 1)); // hold 3, flush ignored
        tbl.push_back(mk(1,  6,  1, 1, 1, 13, 1, 0, 0, 0,  0, 1, 1, 1, 1)); // resume
        tbl.push_back(mk(0,  0,  0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 1, 0, 1)); // x6 forwarded from EX
        tbl.push_back(mk(0,  0,  0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mk(1,  1,  0, 1, 0,  7, 1, 1, 0, 0,  0, 0, 0, 0, 1)); // lw x7
        tbl.push_back(mk(1,  7,  7, 1, 1,  8, 1, 0, 0, 1,  1, 1, 0, 0, 1)); // load-use under hold
        tbl.push_back(mk(1,  7,  7, 1, 1,  8, 1, 0, 0, 0,  1, 1, 0, 0, 1)); // load-use counts now
        tbl.push_back(mk(1,  7,  7, 1, 1,  8, 1, 0, 0, 0,  0, 0, 0, 0, 2));
        tbl.push_back(mk(0,  0,  0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 2, 2, 2));

        foreach (tbl[i]) step(tbl[i], 1'b1, i);

        // Asynchronous reset asserted between edges must clear outputs at once.
        @(negedge clk);
        #2;
        ex_hold = 1'b1;
        rst_n   = 1'b0;
        #1;
        chk("arst_ex_valid", ex_valid, 1'b0);
        chk("arst_fwd_a", fwd_a, 2'b00);
        chk("arst_fwd_b", fwd_b, 2'b00);
        chk("arst_stall_count", stall_count, 32'd0);
        chk("arst_stall_id_hold", stall_id, 1'b1);
        ex_hold = 1'b0;
        #1;
        chk("arst_stall_id_nohold", stall_id, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 600; n++) begin
            rv = mk($urandom_range(0, 9) < 8, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, 5'($urandom_range(0, 3)),
                    $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 4,
                    $urandom_range(0, 9) < 1, $urandom_range(0, 9) < 1,
                    0, 0, 0, 0, 0);
            step(rv, 1'b0, n);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and forwarding controller for the integer pipeline (ID → EX → MEM → WB). It tracks the destination register of every instruction in flight downstream of ID. It drives registered forwarding selects for the EX-stage ALU operand muxes and generates the ID stall for load-use hazards, along with the EX bubble that accompanies it. It also counts load-use stall cycles for performance monitoring.

## Interface
- No parameters; register index width fixed at 5, counter width fixed at 32.
- clk  input  1  pipeline clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- id_valid  input  1  ID holds a valid instruction
- id_rs1, id_rs2  input  5 each  ID source register indices
- id_use_rs1, id_use_rs2  input  1 each  ID instruction actually reads rs1 / rs2
- id_rd  input  5  ID destination index
- id_rd_we  input  1  ID instruction writes rd (ALU, CSR read, load, JAL/JALR)
- id_is_load  input  1  ID instruction is a load (result available only at WB)
- flush  input  1  redirect from EX; ID instruction is wrong-path
- ex_hold  input  1  external freeze of the whole back end (multi-cycle unit busy)
- stall_id  output  1  combinational; freeze PC/IF/ID registers
- ex_valid  output  1  registered; EX holds a valid instruction
- fwd_a, fwd_b  output  2 each  registered operand select for EX: 00 regfile/normal, 01 EX/MEM result, 10 MEM/WB write-back data, 11 unused
- stall_count  output  32  load-use stall cycles since reset

## Operation
- Internal scoreboard: three entries EX, MEM, WB, each {valid, rd, we, is_load}.
- match(stage, rs, use) = stage.valid & stage.we & stage.rd != 0 & stage.rd == rs & use. x0 never matches.
- load_use = id_valid & EX.valid & EX.is_load & (match(EX, id_rs1, id_use_rs1) | match(EX, id_rs2, id_use_rs2)).
- stall_id = ex_hold | (load_use & ~flush).
- Advance when ex_hold = 0:
  - WB ← MEM and MEM ← EX.
  - EX ← ID fields with valid = id_valid & ~load_use & ~flush; otherwise a bubble (valid 0, we 0).
- Forward select for operand a, computed from the pre-advance state and latched on the same edge as EX ← ID:
  - 01 if match(EX, id_rs1, id_use_rs1), where the producer is in EX now and will sit in MEM.
  - Otherwise 10 if match(MEM, id_rs1, id_use_rs1).
  - Otherwise 00.
  - The youngest producer wins.
- Operand b uses the same rule with id_rs2 and id_use_rs2.
- When EX receives a bubble, both forward selects latch 00.
- The WB-stage producer is not forwarded. The register file is write-through in the same cycle.
- stall_count increments by 1, wrapping modulo 2^32, on every edge where ex_hold = 0 & load_use & ~flush.
- ex_hold = 1 freezes everything:
  - Scoreboard, fwd_a/b, ex_valid and stall_count hold.
  - flush is ignored. The redirect source keeps flush asserted until the hold drops.
- Flush and load-use in the same cycle: flush wins. stall_id is 0 unless ex_hold is high, EX receives a bubble, and stall_count does not increment.

## Timing
- Reset (async, rst_n low): all scoreboard valids 0, ex_valid 0, fwd_a/fwd_b 00, stall_count 0. stall_id = ex_hold while in reset.
- stall_id is purely combinational from the inputs and the scoreboard, with zero-cycle latency.
- ex_valid and fwd_a/fwd_b change only on a rising edge and are valid for the whole cycle the instruction occupies EX.
- A load-use stall lasts exactly 1 cycle. On the next edge the load moves to MEM, EX holds a bubble, and the consumer issues with fwd 10 one cycle later.
- Back-to-back issue with no hazard: one instruction enters EX per cycle.

## Test plan
- ALU-to-ALU: add x5 then add x6,x5,x1 back-to-back → second instruction in EX with fwd_a = 01, fwd_b = 00, stall_id never 1.
- Distance 2: add x5 then an independent instruction, then sub x7,x1,x5 → fwd_b = 10. At distance 3 → fwd_b = 00.
- Load-use: lw x7 then add x8,x7,x7 → stall_id = 1 for exactly 1 cycle, ex_valid = 0 in the following cycle, then add in EX with fwd_a = fwd_b = 10, and stall_count = 1.
- x0 and unused sources:
  - Producer with rd = 0 followed by a consumer of x0 → fwd 00.
  - A consumer with id_use_rs2 = 0 whose rs2 matches → fwd_b = 00.
- Flush during load-use: lw x7 in EX, dependent instruction in ID, flush = 1 → stall_id = 0, ex_valid = 0 next cycle, stall_count unchanged.
- Hold then reset:
  - ex_hold = 1 for 3 cycles mid-stream → stall_id = 1, and ex_valid, fwd_a/b and stall_count are frozen. Pipeline resumes exactly after the hold drops.
  - rst_n pulsed low between clock edges → all outputs return to their reset values immediately.
